// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 1:4 TDM receive demultiplexer with frame sync, flywheel and resync
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             fsync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             s1,
    output logic             s0,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    bit_cnt, bit_cnt_nx;
    logic [1:0]       slot, slot_nx;
    logic [WIDTH-2:0] shreg, shreg_nx;
    logic [WIDTH-1:0] y0_nx, y1_nx, y2_nx, y3_nx;
    logic [WIDTH-1:0] word;
    logic             frame_valid_nx, sync_err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            slot        <= '0;
            shreg       <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            slot        <= slot_nx;
            shreg       <= shreg_nx;
            y0          <= y0_nx;
            y1          <= y1_nx;
            y2          <= y2_nx;
            y3          <= y3_nx;
            frame_valid <= frame_valid_nx;
            sync_err    <= sync_err_nx;
        end
    end

    // The shift register only holds WIDTH-1 bits; the last bit of a slot
    // comes straight from din so the word lands on the same edge.
    always_comb begin
        state_nx       = state;
        bit_cnt_nx     = bit_cnt;
        slot_nx        = slot;
        shreg_nx       = shreg;
        y0_nx          = y0;
        y1_nx          = y1;
        y2_nx          = y2;
        y3_nx          = y3;
        frame_valid_nx = 1'b0;
        sync_err_nx    = 1'b0;
        word           = {shreg, din};

        if (en) begin
            if (state == IDLE) begin
                if (fsync) begin
                    state_nx   = RUN;
                    shreg_nx   = word[WIDTH-2:0];
                    bit_cnt_nx = CW'(1);
                    slot_nx    = 2'd0;
                end
            end else begin
                shreg_nx = word[WIDTH-2:0];
                if (fsync && (slot != 2'd0 || bit_cnt != '0)) begin
                    // Misplaced sync: abandon the partial frame and restart here.
                    sync_err_nx = 1'b1;
                    bit_cnt_nx  = CW'(1);
                    slot_nx     = 2'd0;
                end else if (bit_cnt == LAST) begin
                    bit_cnt_nx = '0;
                    slot_nx    = slot + 2'd1;
                    case (slot)
                        2'd0: y0_nx = word;
                        2'd1: y1_nx = word;
                        2'd2: y2_nx = word;
                        default: begin
                            y3_nx          = word;
                            frame_valid_nx = 1'b1;
                        end
                    endcase
                end else begin
                    bit_cnt_nx = bit_cnt + CW'(1);
                end
            end
        end
    end

    assign s1     = slot[1];
    assign s0     = slot[0];
    assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - randomized and directed bench for tdm_demux4 against a frame-position model
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk, rst, en, din, fsync;
    logic [W-1:0] y0, y1, y2, y3;
    logic         s1, s0, frame_valid, sync_err, locked;

    int vectors    = 0;
    int miscompares = 0;
    int fv_seen    = 0;
    int se_seen    = 0;

    // model: frame position of the next bit, and the words it implies
    bit           mlock;
    int           pos;
    logic [W-1:0] acc;
    logic [W-1:0] ey [4];
    bit           efv, ese;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .fsync(fsync),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .s1(s1), .s0(s0), .frame_valid(frame_valid),
        .sync_err(sync_err), .locked(locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mlock = 0;
        pos   = 0;
        acc   = '0;
        efv   = 0;
        ese   = 0;
        for (int i = 0; i < 4; i++) ey[i] = '0;
    endtask

    task automatic model_edge(input bit e, input bit d, input bit f);
        efv = 0;
        ese = 0;
        if (e) begin
            if (!mlock) begin
                if (f) begin
                    mlock = 1;
                    pos   = 0;
                end
            end else if (f && pos != 0) begin
                ese = 1;
                pos = 0;
            end
            if (mlock) begin
                acc = {acc[W-2:0], d};
                pos++;
                if (pos % W == 0) begin
                    ey[pos / W - 1] = acc;
                    if (pos == 4 * W) begin
                        efv = 1;
                        pos = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("y0", y0, ey[0]);
        check("y1", y1, ey[1]);
        check("y2", y2, ey[2]);
        check("y3", y3, ey[3]);
        check("slot", {s1, s0}, 32'(pos / W));
        check("frame_valid", frame_valid, efv);
        check("sync_err", sync_err, ese);
        check("locked", locked, mlock);
        if (frame_valid) fv_seen++;
        if (sync_err) se_seen++;
    endtask

    task automatic step(input bit e, input bit d, input bit f);
        en    = e;
        din   = d;
        fsync = f;
        @(posedge clk);
        model_edge(e, d, f);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    // 16-bit frame, MSB first; gap>0 inserts that many en=0 cycles after every 2nd beat
    task automatic send_frame(input logic [15:0] bits, input bit sync, input int gap);
        logic [15:0] b;
        b = bits;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, b[15 - i], (i == 0) ? sync : 1'b0);
            if (gap > 0 && (i % 2) == 1 && i != 15)
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; fsync = 1'b0;
        model_reset();
        #2;
        check_all();
        #1;
        rst = 1'b0;

        // basic frame
        fv_seen = 0;
        send_frame(16'b1010_0101_1100_0011, 1'b1, 0);
        check("t1_y0", y0, 4'hA);
        check("t1_y1", y1, 4'h5);
        check("t1_y2", y2, 4'hC);
        check("t1_y3", y3, 4'h3);
        check("t1_fv", frame_valid, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("t1_fv_once", fv_seen, 1);

        // gapped enable
        async_reset();
        fv_seen = 0;
        send_frame(16'b1010_0101_1100_0011, 1'b1, 3);
        check("t2_y0", y0, 4'hA);
        check("t2_y3", y3, 4'h3);
        check("t2_fv", frame_valid, 1'b1);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b1);
        check("t2_fv_once", fv_seen, 1);

        // flywheel back-to-back
        async_reset();
        fv_seen = 0;
        se_seen = 0;
        send_frame(16'b1010_0101_1100_0011, 1'b1, 0);
        send_frame(16'b0001_0010_0011_0100, 1'b0, 0);
        check("t3_y0", y0, 4'h1);
        check("t3_y1", y1, 4'h2);
        check("t3_y2", y2, 4'h3);
        check("t3_y3", y3, 4'h4);
        check("t3_fv_count", fv_seen, 2);
        check("t3_no_err", se_seen, 0);

        // misaligned fsync on beat 6
        async_reset();
        fv_seen = 0;
        se_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, (i < 4) ? 1'(i % 2 == 0) : 1'b0, i == 0);
        check("t4_y0_aborted", y0, 4'hA);
        send_frame(16'b0110_1001_1111_0001, 1'b1, 0);
        check("t4_err_count", se_seen, 1);
        check("t4_fv_count", fv_seen, 1);
        check("t4_y0", y0, 4'h6);
        check("t4_y3", y3, 4'h1);

        // pre-lock beats, then reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("t5_unlocked", locked, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom_range(0, 1)), i == 0);
        async_reset();
        check("t5_rst_locked", locked, 1'b0);
        check("t5_rst_y0", y0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit e, f;
            e = ($urandom_range(0, 3) != 0);
            if (mlock && pos == 0) f = 1'($urandom_range(0, 1));
            else                   f = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
            else step(e, 1'($urandom_range(0, 1)), f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1:4 demultiplexer: the receive-side counterpart of the team's 4:1 mux.
- Accepts a serial bit stream framed by a sync pulse, steers each slot's bits into one of four channel registers (y0..y3) by an internal 2-bit slot select {s1,s0}, and flags each completed frame.
- Sits at the receive end of the 4-channel TDM link, feeding per-channel parallel consumers.

Parameters:
WIDTH  4  bits per channel slot (>=2); frame length = 4*WIDTH enabled cycles

Ports:
clk          input   1      rising-edge clock
rst          input   1      asynchronous reset, active-high
en           input   1      bit-valid qualifier; din/fsync sampled only when en=1
din          input   1      serial data bit, MSB of each slot first
fsync        input   1      frame-start marker, coincident with bit 0 of slot 0
y0           output  WIDTH  channel 0 word (slot 0)
y1           output  WIDTH  channel 1 word (slot 1)
y2           output  WIDTH  channel 2 word (slot 2)
y3           output  WIDTH  channel 3 word (slot 3)
s1           output  1      current slot select MSB
s0           output  1      current slot select LSB
frame_valid  output  1      1-cycle pulse: y0..y3 hold a complete, consistent frame
sync_err     output  1      1-cycle pulse: fsync arrived off a frame boundary
locked       output  1      1 while in RUN state

Behaviour:
- Reset (async, rst=1): y0..y3=0, s1=s0=0, frame_valid=0, sync_err=0, locked=0; bit counter and shift register cleared; state=IDLE.
  - Reset asserted mid-frame discards the partial frame; no frame_valid is produced.
- Qualification: a "beat" is a rising edge with en=1. Edges with en=0 change nothing except pulse outputs, which drop to 0. fsync with en=0 is ignored.
- States:
  - IDLE: beats without fsync ignored. Beat with fsync=1: go to RUN, locked=1; din becomes bit 0 of slot 0; bit_cnt=1, slot=0.
  - RUN: every beat shifts din into the shift register (MSB first) and increments bit_cnt.
- Slot completion: on the beat where bit_cnt==WIDTH-1, the word {shreg[WIDTH-2:0],din} is written to y[slot] at that same edge (output latency 1 edge after the last bit). bit_cnt wraps to 0; slot increments.
- Slot select: {s1,s0} reflects the slot receiving the next bit. Wraps 3->0.
- Frame completion: when slot 3 completes, frame_valid=1 for exactly one cycle, coincident with the y3 update.
  - y0..y2 are not rewritten again until the next frame's slots complete.
  - Consumers sample all four words on frame_valid.
- Flywheel: in RUN, fsync=0 at a frame boundary (slot 0, bit 0) is legal; reception continues.
- Resync: in RUN, a beat with fsync=1 at any position other than slot 0/bit 0:
  - sync_err=1 for one cycle.
  - The partial frame is aborted (no frame_valid; y registers already written this frame keep their values).
  - That beat is treated as bit 0 of slot 0 (bit_cnt=1, slot=0); state stays RUN.
- fsync=1 exactly at the boundary: no error, normal restart.
- Simultaneous completion and fsync cannot occur: the boundary beat is bit 0, not a completion beat.
- Held words: y registers keep their last value indefinitely while en=0 or while in IDLE.

Test Plan:
1. Basic frame (WIDTH=4): rst pulse, then 16 consecutive beats, fsync on beat 1, din=1010_0101_1100_0011 -> after beat 16: y0=0xA, y1=0x5, y2=0xC, y3=0x3; frame_valid=1 for one cycle; locked=1; {s1,s0}=00.
2. Gapped enable: same frame with en=0 inserted for 3 cycles after every 2nd beat -> identical y values; frame_valid exactly once, one edge after the 16th beat; outputs unchanged during gaps.
3. Flywheel back-to-back: two frames, fsync only on the first; second frame = 0x1,0x2,0x3,0x4 -> two frame_valid pulses 16 beats apart; second yields y0..y3 = 1,2,3,4; sync_err never asserts.
4. Misaligned fsync: fsync on beat 6 of a frame -> sync_err pulse that cycle; no frame_valid for the aborted frame; next 16 beats from beat 6 decode correctly; y0 from the aborted frame is retained until overwritten.
5. Pre-lock and reset mid-frame: 5 beats with no fsync in IDLE -> y unchanged, locked=0. Then lock, and assert rst after 9 beats -> all outputs 0 immediately (asynchronous), state IDLE, no frame_valid.
6. Slot select trace: during test 1, {s1,s0} = 00 for beats 1-3, 01 after beat 4, 10 after beat 8, 11 after beat 12, 00 after beat 16.
